// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS bidirectional I/O ports: output latch, direction,
// synchronised inputs, and maskable change-detect flags feeding a single interrupt.
module io_port_bank #(
   parameter int DATA_W      = 8,
   parameter int NUM_PORTS   = 8,
   parameter int ADDR_W      = 8,
   parameter int BASE_ADDR   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [ADDR_W-1:0]             addr,
   input  logic                          RE,
   input  logic                          WE,
   input  logic [DATA_W-1:0]             Din,
   output logic [DATA_W-1:0]             Dout,
   output logic                          rd_valid,
   output logic                          io_read,
   output logic                          io_write,
   input  logic [NUM_PORTS*DATA_W-1:0]   pin_in,
   output logic [NUM_PORTS*DATA_W-1:0]   pin_out,
   output logic [NUM_PORTS*DATA_W-1:0]   pin_oe,
   output logic                          irq
);

   localparam int                PW   = NUM_PORTS * DATA_W;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   SPAN = (ADDR_W+1)'(4 * NUM_PORTS);

   logic [ADDR_W-1:0]    off;
   logic                 hit;

   logic [PW-1:0]        latch_q, latch_d;
   logic [PW-1:0]        dir_q, dir_d;
   logic [PW-1:0]        flag_q, flag_d;
   logic [PW-1:0]        mask_q, mask_d;
   logic [PW-1:0]        sync_q [SYNC_STAGES];
   logic [PW-1:0]        prev_q;
   logic [PW-1:0]        sync;

   logic [NUM_PORTS-1:0] wr_data, wr_dir, wr_chg, wr_mask;
   logic [DATA_W-1:0]    rd_mux;

   logic [DATA_W-1:0]    dout_q, dout_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 irq_q, irq_d;

   // The offset is taken modulo 2**ADDR_W; the explicit lower-bound test stops
   // addresses below BASE from wrapping into the bank.
   assign off      = addr - BASE;
   assign hit      = (addr >= BASE) && ({1'b0, off} < SPAN);
   assign io_read  = RE && hit;
   assign io_write = WE && hit;

   assign sync     = sync_q[SYNC_STAGES-1];

   always_comb begin
      wr_data = '0;
      wr_dir  = '0;
      wr_chg  = '0;
      wr_mask = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         wr_data[i] = io_write && (off == ADDR_W'(i));
         wr_dir[i]  = io_write && (off == ADDR_W'(NUM_PORTS + i));
         wr_chg[i]  = io_write && (off == ADDR_W'(2 * NUM_PORTS + i));
         wr_mask[i] = io_write && (off == ADDR_W'(3 * NUM_PORTS + i));
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (off == ADDR_W'(i))
            rd_mux = (latch_q[i*DATA_W +: DATA_W] & dir_q[i*DATA_W +: DATA_W])
                   | (sync[i*DATA_W +: DATA_W]    & ~dir_q[i*DATA_W +: DATA_W]);
         if (off == ADDR_W'(NUM_PORTS + i))
            rd_mux = dir_q[i*DATA_W +: DATA_W];
         if (off == ADDR_W'(2 * NUM_PORTS + i))
            rd_mux = flag_q[i*DATA_W +: DATA_W];
         if (off == ADDR_W'(3 * NUM_PORTS + i))
            rd_mux = mask_q[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      latch_d = latch_q;
      dir_d   = dir_q;
      mask_d  = mask_q;
      flag_d  = flag_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (wr_data[i]) latch_d[i*DATA_W +: DATA_W] = Din;
         if (wr_dir[i])  dir_d[i*DATA_W +: DATA_W]   = Din;
         if (wr_mask[i]) mask_d[i*DATA_W +: DATA_W]  = Din;
         if (wr_chg[i])  flag_d[i*DATA_W +: DATA_W]  = flag_q[i*DATA_W +: DATA_W] & ~Din;
      end
      // Clear first, then set, so a fresh edge survives a concurrent W1C.
      flag_d = flag_d | ((sync ^ prev_q) & ~dir_q);
   end

   assign dout_d     = io_read ? rd_mux : dout_q;
   assign rd_valid_d = io_read;
   assign irq_d      = |(flag_q & mask_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_q    <= '0;
         dir_q      <= '0;
         flag_q     <= '0;
         mask_q     <= '0;
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         latch_q    <= latch_d;
         dir_q      <= dir_d;
         flag_q     <= flag_d;
         mask_q     <= mask_d;
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
         irq_q      <= irq_d;
      end
   end

   assign Dout     = dout_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;
   assign pin_out  = latch_q;
   assign pin_oe   = dir_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed scenarios then random traffic, all checked
// against a register/queue model of the bank's documented behaviour.
module tb_io_port_bank;
   localparam int W    = 8;
   localparam int N    = 2;
   localparam int AW   = 8;
   localparam int BASE = 'h40;
   localparam int S    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          RE = 1'b0;
   logic          WE = 1'b0;
   logic [W-1:0]  Din = '0;
   logic [W-1:0]  Dout;
   logic          rd_valid, io_read, io_write, irq;
   logic [N*W-1:0] pin_in = '0;
   logic [N*W-1:0] pin_out, pin_oe;

   io_port_bank #(
      .DATA_W(W), .NUM_PORTS(N), .ADDR_W(AW), .BASE_ADDR(BASE), .SYNC_STAGES(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .RE(RE), .WE(WE), .Din(Din),
      .Dout(Dout), .rd_valid(rd_valid), .io_read(io_read), .io_write(io_write),
      .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [W-1:0]   m_latch [N];
   logic [W-1:0]   m_dir   [N];
   logic [W-1:0]   m_flag  [N];
   logic [W-1:0]   m_mask  [N];
   logic [W-1:0]   m_dout;
   logic           m_rv, m_irq;
   logic [N*W-1:0] hist [$];
   logic [N*W-1:0] m_prev;
   logic [N*W-1:0] pins = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit f_hit(input logic [AW-1:0] a);
      int o;
      o = int'(a) - BASE;
      return (o >= 0) && (o < 4 * N);
   endfunction

   task automatic model_reset();
      for (int q = 0; q < N; q++) begin
         m_latch[q] = '0; m_dir[q] = '0; m_flag[q] = '0; m_mask[q] = '0;
      end
      m_dout = '0; m_rv = 1'b0; m_irq = 1'b0; m_prev = '0;
      hist.delete();
      for (int k = 0; k < S; k++) hist.push_back('0);
   endtask

   // Advance the model across one rising edge with the given bus/pin inputs.
   task automatic model_edge(input logic re, input logic we, input logic [AW-1:0] a,
                             input logic [W-1:0] d, input logic [N*W-1:0] p);
      int off, region, port;
      bit hit;
      logic [N*W-1:0] sy, ch;
      logic [W-1:0] clr;
      sy     = hist[0];
      ch     = sy ^ m_prev;
      hit    = f_hit(a);
      off    = int'(a) - BASE;
      region = hit ? off / N : 0;
      port   = hit ? off % N : 0;
      m_irq = 1'b0;
      for (int q = 0; q < N; q++) if ((m_flag[q] & m_mask[q]) != 0) m_irq = 1'b1;
      m_rv = re && hit;
      if (re && hit) begin
         case (region)
            0: m_dout = (m_latch[port] & m_dir[port]) | (sy[port*W +: W] & ~m_dir[port]);
            1: m_dout = m_dir[port];
            2: m_dout = m_flag[port];
            default: m_dout = m_mask[port];
         endcase
      end
      for (int q = 0; q < N; q++) begin
         clr = (we && hit && region == 2 && port == q) ? d : '0;
         m_flag[q] = (m_flag[q] & ~clr) | (ch[q*W +: W] & ~m_dir[q]);
      end
      if (we && hit) begin
         case (region)
            0: m_latch[port] = d;
            1: m_dir[port]   = d;
            3: m_mask[port]  = d;
            default: ;
         endcase
      end
      m_prev = sy;
      hist.push_back(p);
      void'(hist.pop_front());
   endtask

   task automatic check_regs();
      logic [N*W-1:0] eo, eoe;
      for (int q = 0; q < N; q++) begin
         eo[q*W +: W]  = m_latch[q];
         eoe[q*W +: W] = m_dir[q];
      end
      chk("Dout", Dout, m_dout);
      chk("rd_valid", rd_valid, m_rv);
      chk("irq", irq, m_irq);
      chk("pin_out", pin_out, eo);
      chk("pin_oe", pin_oe, eoe);
   endtask

   // One bus cycle: called at a falling edge, returns at the next falling edge.
   task automatic cyc(input logic re, input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d);
      check_regs();
      RE = re; WE = we; addr = a; Din = d; pin_in = pins;
      #1;
      chk("io_read", io_read, re && f_hit(a));
      chk("io_write", io_write, we && f_hit(a));
      model_edge(re, we, a, d, pins);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      chk("rst Dout", Dout, 0);
      chk("rst rd_valid", rd_valid, 0);
      chk("rst irq", irq, 0);
      chk("rst pin_oe", pin_oe, 0);
      chk("rst pin_out", pin_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Input port read through the synchroniser
      pins = 16'h00A5;
      idle(3);
      cyc(1'b1, 1'b0, 8'h40, '0);
      chk("rd port0 data", Dout, 8'hA5);
      chk("rd port0 valid", rd_valid, 1);
      idle(1);
      chk("rd_valid pulse", rd_valid, 0);
      chk("pin_oe inputs", pin_oe, 0);

      // Mixed direction port
      cyc(1'b0, 1'b1, 8'h42, 8'hF0);
      cyc(1'b0, 1'b1, 8'h40, 8'h3C);
      pins = 16'h000F;
      idle(3);
      chk("pin_out0", pin_out[7:0], 8'h3C);
      chk("pin_oe0", pin_oe[7:0], 8'hF0);
      cyc(1'b1, 1'b0, 8'h40, '0);
      chk("rd mixed", Dout, 8'h3F);

      // Change detect and interrupt on port 1 bit 0
      cyc(1'b0, 1'b1, 8'h44, 8'hFF);
      cyc(1'b0, 1'b1, 8'h45, 8'hFF);
      cyc(1'b0, 1'b1, 8'h47, 8'h01);
      idle(2);
      pins = 16'h010F;
      idle(3);
      chk("irq before", irq, 0);
      cyc(1'b1, 1'b0, 8'h45, '0);
      chk("chg1 set", Dout, 8'h01);
      chk("irq set", irq, 1);
      cyc(1'b0, 1'b1, 8'h45, 8'h01);
      chk("irq hold", irq, 1);
      idle(1);
      chk("irq cleared", irq, 0);

      // W1C colliding with a new change: the set wins
      pins = 16'h000F;
      idle(2);
      cyc(1'b0, 1'b1, 8'h45, 8'h01);
      cyc(1'b1, 1'b0, 8'h45, '0);
      chk("set wins chg1", Dout, 8'h01);
      chk("set wins irq", irq, 1);
      cyc(1'b0, 1'b1, 8'h45, 8'h01);
      idle(2);

      // Bank edges
      cyc(1'b1, 1'b1, 8'h3F, 8'hAA);
      cyc(1'b1, 1'b1, 8'h48, 8'hAA);
      cyc(1'b1, 1'b0, 8'h47, '0);
      chk("mask1 hit", Dout, 8'h01);
      chk("mask1 valid", rd_valid, 1);

      // Read and write on the same cycle return the old value
      cyc(1'b0, 1'b1, 8'h42, 8'hFF);
      cyc(1'b0, 1'b1, 8'h40, 8'h11);
      cyc(1'b1, 1'b1, 8'h40, 8'h22);
      chk("rw old data", Dout, 8'h11);
      chk("rw new latch", pin_out[7:0], 8'h22);

      // Reset mid-transfer aborts the pending write
      check_regs();
      RE = 1'b0; WE = 1'b1; addr = 8'h40; Din = 8'h99;
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst Dout", Dout, 0);
      chk("mid rst pin_out", pin_out, 0);
      chk("mid rst pin_oe", pin_oe, 0);
      chk("mid rst irq", irq, 0);
      model_reset();
      @(negedge clk);
      WE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("post rst pin_out", pin_out, 0);

      // Random traffic
      for (int it = 0; it < 1500; it++) begin
         logic r, w;
         logic [AW-1:0] a;
         logic [W-1:0] d;
         if ($urandom_range(0, 3) == 0) pins = N*W'($urandom);
         r = ($urandom_range(0, 2) == 0);
         w = ($urandom_range(0, 2) == 0);
         a = AW'(8'h3C + $urandom_range(0, 15));
         d = W'($urandom);
         cyc(r, w, a, d);
      end
      check_regs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
